// File: rtl/branch_history_predictor.sv
// Per-PC 2-bit saturating-counter branch predictor with saturating branch and
// mispredict statistics. Prediction and mispredict detection are combinational.
module branch_history_predictor #(
  parameter int unsigned IndexBits = 4,
  parameter int unsigned PcBits    = 32,
  parameter int unsigned InitState = 1,
  parameter int unsigned StatBits  = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                ClockEnable,
  input  logic                Tick,
  input  logic [PcBits-1:0]   IfPc,
  input  logic                IfIsBranch,
  output logic                PredictJump,
  input  logic                ExValid,
  input  logic [PcBits-1:0]   ExPc,
  input  logic                ExPredicted,
  input  logic                ExTaken,
  output logic                Mispredict,
  output logic [StatBits-1:0] BranchCount,
  output logic [StatBits-1:0] MispredictCount
);

  localparam int unsigned Entries = 1 << IndexBits;
  localparam logic [1:0]  InitCtr = 2'(InitState);

  logic [1:0]           ctr_q [Entries];
  logic [IndexBits-1:0] if_idx;
  logic [IndexBits-1:0] ex_idx;
  logic                 upd;

  // Word-aligned index; upper PC bits alias onto the same entry.
  assign if_idx = IfPc[IndexBits+1:2];
  assign ex_idx = ExPc[IndexBits+1:2];
  assign upd    = ClockEnable & Tick & ExValid & ~Reset;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{IfPc[PcBits-1:IndexBits+2], IfPc[1:0],
                            ExPc[PcBits-1:IndexBits+2], ExPc[1:0]};

  always_comb begin
    PredictJump = IfIsBranch & ctr_q[if_idx][1];
    Mispredict  = ExValid & (ExPredicted ^ ExTaken);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        ctr_q[IndexBits'(i)] <= InitCtr;
      end
    end else if (upd) begin
      if (ExTaken) begin
        if (ctr_q[ex_idx] != 2'd3) ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
      end else begin
        if (ctr_q[ex_idx] != 2'd0) ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      BranchCount     <= '0;
      MispredictCount <= '0;
    end else if (upd) begin
      if (BranchCount != '1) BranchCount <= BranchCount + StatBits'(1);
      if (Mispredict && (MispredictCount != '1))
        MispredictCount <= MispredictCount + StatBits'(1);
    end
  end

endmodule

// File: tb/tb_branch_history_predictor.sv
// Self-checking bench for branch_history_predictor: vector table with a scoreboard
// queue, plus hand-written sequences for same-index update, saturation and reset.
module tb_branch_history_predictor;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        ClockEnable, Tick, IfIsBranch, ExValid, ExPredicted, ExTaken;
  logic [31:0] IfPc, ExPc;
  logic        pj, mp, pj4, mp4;
  logic [15:0] bc, mc;
  logic [3:0]  bc4, mc4;

  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  branch_history_predictor dut (
    .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
    .IfPc(IfPc), .IfIsBranch(IfIsBranch), .PredictJump(pj),
    .ExValid(ExValid), .ExPc(ExPc), .ExPredicted(ExPredicted), .ExTaken(ExTaken),
    .Mispredict(mp), .BranchCount(bc), .MispredictCount(mc)
  );

  branch_history_predictor #(.StatBits(4)) dut4 (
    .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
    .IfPc(IfPc), .IfIsBranch(IfIsBranch), .PredictJump(pj4),
    .ExValid(ExValid), .ExPc(ExPc), .ExPredicted(ExPredicted), .ExTaken(ExTaken),
    .Mispredict(mp4), .BranchCount(bc4), .MispredictCount(mc4)
  );

  typedef struct {
    logic [31:0] if_pc;
    logic        if_br, ce, tick, ex_v;
    logic [31:0] ex_pc;
    logic        ex_p, ex_t;
    logic        exp_pj, exp_mp;   // before the edge
    int          exp_bc, exp_mc;   // after the edge
  } vec_t;

  typedef struct {
    logic pj, mp;
    int   bc, mc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic drive(input logic [31:0] ipc, input logic ibr, input logic ce,
                       input logic tk, input logic ev, input logic [31:0] epc,
                       input logic ep, input logic et);
    IfPc = ipc; IfIsBranch = ibr; ClockEnable = ce; Tick = tk;
    ExValid = ev; ExPc = epc; ExPredicted = ep; ExTaken = et;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic [31:0] ipc, input logic ibr, input logic ce,
                              input logic tk, input logic ev, input logic [31:0] epc,
                              input logic ep, input logic et, input logic xpj,
                              input logic xmp, input int xbc, input int xmc);
    vec_t v;
    v.if_pc = ipc; v.if_br = ibr; v.ce = ce; v.tick = tk; v.ex_v = ev; v.ex_pc = epc;
    v.ex_p = ep; v.ex_t = et; v.exp_pj = xpj; v.exp_mp = xmp; v.exp_bc = xbc; v.exp_mc = xmc;
    return v;
  endfunction

  initial begin
    exp_t e;
    // Entry 0 (PC 0x40) and entry 2 (PC 0x48) trained from InitState=1.
    vecs.push_back(mk(32'h40, 1, 1, 1, 1, 32'h40, 0, 1, 0, 1, 1, 1)); // 1->2
    vecs.push_back(mk(32'h40, 1, 1, 1, 1, 32'h40, 1, 1, 1, 0, 2, 1)); // 2->3
    vecs.push_back(mk(32'h40, 1, 1, 1, 1, 32'h40, 1, 1, 1, 0, 3, 1)); // 3->3
    vecs.push_back(mk(32'h44, 1, 1, 1, 0, 32'h0,  0, 0, 0, 0, 3, 1)); // other entry
    vecs.push_back(mk(32'h40, 1, 1, 1, 1, 32'h40, 1, 0, 1, 1, 4, 2)); // 3->2
    vecs.push_back(mk(32'h40, 0, 1, 1, 0, 32'h0,  0, 0, 0, 0, 4, 2)); // non-branch
    vecs.push_back(mk(32'h40, 1, 0, 1, 1, 32'h40, 1, 1, 1, 0, 4, 2)); // stall
    vecs.push_back(mk(32'h40, 1, 1, 0, 1, 32'h40, 1, 0, 1, 1, 4, 2)); // no tick
    vecs.push_back(mk(32'h40, 1, 0, 0, 1, 32'h40, 0, 1, 1, 1, 4, 2));
    vecs.push_back(mk(32'h40, 1, 0, 0, 0, 32'h40, 1, 0, 1, 0, 4, 2)); // ExValid=0
    vecs.push_back(mk(32'h48, 1, 1, 1, 1, 32'h48, 0, 1, 0, 1, 5, 3)); // e2 1->2
    vecs.push_back(mk(32'h88, 1, 1, 1, 0, 32'h0,  0, 0, 1, 0, 5, 3)); // alias of 0x48
    vecs.push_back(mk(32'h4B, 1, 1, 1, 0, 32'h0,  0, 0, 1, 0, 5, 3)); // PC[1:0] ignored
    vecs.push_back(mk(32'h48, 1, 1, 1, 1, 32'h48, 1, 0, 1, 1, 6, 4)); // 2->1
    vecs.push_back(mk(32'h48, 1, 1, 1, 1, 32'h48, 0, 0, 0, 0, 7, 4)); // 1->0
    vecs.push_back(mk(32'h48, 1, 1, 1, 1, 32'h48, 0, 0, 0, 0, 8, 4)); // 0->0
    vecs.push_back(mk(32'h48, 1, 1, 1, 1, 32'h48, 0, 1, 0, 1, 9, 5)); // 0->1
    vecs.push_back(mk(32'h48, 1, 1, 1, 0, 32'h0,  0, 0, 0, 0, 9, 5));

    Reset = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #12;
    Reset = 1'b0;

    // Reset state
    @(negedge Clock);
    for (int i = 0; i < 4; i++) begin
      drive(32'h40 + 32'(i * 4), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      #1 chk("reset_pj", int'(pj), 0);
    end
    chk("reset_bc", int'(bc), 0);
    chk("reset_mc", int'(mc), 0);

    foreach (vecs[i]) begin
      @(negedge Clock);
      drive(vecs[i].if_pc, vecs[i].if_br, vecs[i].ce, vecs[i].tick, vecs[i].ex_v,
            vecs[i].ex_pc, vecs[i].ex_p, vecs[i].ex_t);
      e.pj = vecs[i].exp_pj; e.mp = vecs[i].exp_mp;
      e.bc = vecs[i].exp_bc; e.mc = vecs[i].exp_mc;
      sb.push_back(e);
      #1;
      chk($sformatf("v%0d_pj", i), int'(pj), int'(sb[0].pj));
      chk($sformatf("v%0d_mp", i), int'(mp), int'(sb[0].mp));
      @(posedge Clock);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_bc", i), int'(bc), e.bc);
      chk($sformatf("v%0d_mc", i), int'(mc), e.mc);
      chk($sformatf("v%0d_bc4", i), int'(bc4), e.bc);
      chk($sformatf("v%0d_mc4", i), int'(mc4), e.mc);
    end

    // 20 mispredicting updates: 4-bit stats saturate, 16-bit keep counting.
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      drive(32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 1'b0);
    end
    @(negedge Clock);
    drive(32'h40, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 1'b0);
    #1;
    chk("sat_bc4", int'(bc4), 15);
    chk("sat_mc4", int'(mc4), 15);
    chk("sat_bc16", int'(bc), 29);
    chk("sat_mc16", int'(mc), 25);
    chk("pre_rst_pj", int'(pj), 1);

    // Reset asserted while clock is high, with an update pending.
    ClockEnable = 1'b1; Tick = 1'b1;
    @(posedge Clock);
    #2 Reset = 1'b1;
    #1;
    chk("midrst_bc", int'(bc), 0);
    chk("midrst_mc", int'(mc), 0);
    chk("midrst_bc4", int'(bc4), 0);
    chk("midrst_pj", int'(pj), 0);
    chk("midrst_mp", int'(mp), 1);
    @(posedge Clock);
    #1;
    chk("rst_edge_bc", int'(bc), 0);
    chk("rst_edge_pj", int'(pj), 0);
    @(negedge Clock);
    Reset = 1'b0;

    // Same-index read/write: old value before the edge, new value after.
    do_reset();
    drive(32'h80, 1'b1, 1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 1'b1);
    #1 chk("same_idx_before", int'(pj), 0);
    @(posedge Clock);
    #1 chk("same_idx_after", int'(pj), 1);
    ClockEnable = 1'b0;
    IfPc = 32'h80 + (32'h4 << 4);
    #1 chk("alias_after", int'(pj), 1);
    IfPc = 32'h84;
    #1 chk("neighbour", int'(pj), 0);
    chk("same_idx_bc", int'(bc), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete, total=%0d", total);
    $fatal(1);
  end

endmodule
